// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands, drives the ALU inputs, samples the result after SETTLE cycles and
// returns tagged responses in order. Define ALU_CHECK_EN to enable the internal result checker.
module alu_cmd_issuer #(
   parameter int unsigned W      = 8,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [W-1:0]     cmd_a,
   input  logic [W-1:0]     cmd_b,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   output logic [2:0]       alu_sel,
   input  logic [W-1:0]     alu_result,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [W-1:0]     rsp_result,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy,
   output logic             chk_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(SETTLE + 1);
   localparam int unsigned DW = 3 + 2 * W + TAG_W;

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e           state;
   logic [DW-1:0]    mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [CW-1:0]    cnt;
   logic [TAG_W-1:0] cur_tag;
   logic [DW-1:0]    head;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             hs;
   logic             capture;

   // Extra pointer MSB distinguishes full from empty.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign hs        = rsp_valid && rsp_ready;
   assign pop       = !empty && ((state == StIdle) || ((state == StResp) && hs));
   assign head      = mem[rd_ptr[AW-1:0]];
   assign capture   = (state == StIssue) && (cnt == CW'(1));
   assign busy      = (state != StIdle) || !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         cur_tag    <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_tag    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr                            <= rd_ptr + 1'b1;
            {alu_sel, alu_a, alu_b, cur_tag}  <= head;
            cnt                               <= CW'(SETTLE);
         end
         unique case (state)
            StIdle: begin
               if (pop) begin
                  state <= StIssue;
               end
            end
            StIssue: begin
               if (capture) begin
                  rsp_result <= alu_result;
                  rsp_carry  <= alu_carry;
                  rsp_zero   <= (alu_result == '0);
                  rsp_tag    <= cur_tag;
                  rsp_valid  <= 1'b1;
                  state      <= StResp;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            StResp: begin
               if (hs) begin
                  rsp_valid <= 1'b0;
                  state     <= pop ? StIssue : StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef ALU_CHECK_EN
   logic [W-1:0] exp_result;
   logic [W:0]   exp_sum;

   always_comb begin
      exp_sum = {1'b0, alu_a} + {1'b0, alu_b};
      unique case (alu_sel)
         3'b000:  exp_result = exp_sum[W-1:0];
         3'b001:  exp_result = alu_a - alu_b;
         3'b010:  exp_result = alu_a * alu_b;
         3'b011:  exp_result = alu_a & alu_b;
         3'b100:  exp_result = alu_a | alu_b;
         3'b101:  exp_result = ~alu_a;
         3'b110:  exp_result = alu_a ^ alu_b;
         default: exp_result = ~(alu_a ^ alu_b);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_err <= 1'b0;
      end else if (capture && ((alu_result != exp_result) || (alu_carry != exp_sum[W]))) begin
         chk_err <= 1'b1;
      end
   end
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomised scoreboard bench for alu_cmd_issuer with a behavioural ALU attached.
module tb_alu_cmd_issuer;

   localparam int unsigned W      = 8;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned SETTLE = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [W-1:0]     cmd_a;
   logic [W-1:0]     cmd_b;
   logic [TAG_W-1:0] cmd_tag;
   logic [W-1:0]     alu_a;
   logic [W-1:0]     alu_b;
   logic [2:0]       alu_sel;
   logic [W-1:0]     alu_result;
   logic             alu_carry;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [W-1:0]     rsp_result;
   logic             rsp_carry;
   logic             rsp_zero;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;
   logic             chk_err;

   alu_cmd_issuer #(.W(W), .TAG_W(TAG_W), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag), .alu_a(alu_a), .alu_b(alu_b),
      .alu_sel(alu_sel), .alu_result(alu_result), .alu_carry(alu_carry), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
      .rsp_zero(rsp_zero), .rsp_tag(rsp_tag), .busy(busy), .chk_err(chk_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]     res;
      logic             c;
      logic             z;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   hs_cyc[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   tput_on = 1'b0;
   int   n_rsp   = 0;

   function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      int unsigned ia = a;
      int unsigned ib = b;
      int unsigned r;
      case (op)
         3'd0: r = ia + ib;
         3'd1: r = ia - ib;
         3'd2: r = ia * ib;
         3'd3: r = ia & ib;
         3'd4: r = ia | ib;
         3'd5: r = ~ia;
         3'd6: r = ia ^ ib;
         default: r = ~(ia ^ ib);
      endcase
      return W'(r % (1 << W));
   endfunction

   function automatic logic ref_carry(input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned s = a + b;
      return (s >= (1 << W));
   endfunction

   // Behavioural ALU standing in for the real combinational instance.
   always_comb begin
      alu_result = ref_res(alu_sel, alu_a, alu_b);
      alu_carry  = ref_carry(alu_a, alu_b);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: values at the negedge are what the next rising edge will see.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (tput_on) hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_rsp: got tag %0h result %0h, expected no response",
                        rsp_tag, rsp_result);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("rsp", {15'd0, rsp_result, rsp_carry, rsp_zero, rsp_tag},
                     {15'd0, e.res, e.c, e.z, e.tag});
            end
         end
         if (cmd_valid && cmd_ready) begin
            exp_t e;
            e.res = ref_res(cmd_op, cmd_a, cmd_b);
            e.c   = ref_carry(cmd_a, cmd_b);
            e.z   = (e.res == '0);
            e.tag = cmd_tag;
            exp_q.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TAG_W-1:0] tag);
      bit acc = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_tag   = tag;
      for (int i = 0; i < 200 && !acc; i++) begin
         acc = cmd_ready;
         step();
      end
      if (!acc) check("send_timeout", 0, 1);
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      rsp_ready = 1'b1;
      while ((busy || rsp_valid) && n < 200) begin
         step();
         n++;
      end
      check("drain_done", {31'd0, busy || rsp_valid}, 0);
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   logic [2:0]   f_op[5];
   logic [W-1:0] f_a[5];
   logic [W-1:0] f_b[5];

   initial begin
      int n;
      int acc_cnt;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
      rsp_ready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_alu", {13'd0, alu_sel, alu_a, alu_b}, 0);
      check("rst_rsp_fields", {17'd0, rsp_result, rsp_carry, rsp_zero, rsp_tag}, 0);
      check("rst_chk_err", {31'd0, chk_err}, 0);

      // Latency: accept at edge 0, response after edge 1+SETTLE.
      send(3'b000, 8'hF0, 8'h20, 4'd3);
      n = 0;
      while (!rsp_valid && n < 20) begin
         step();
         n++;
      end
      check("latency", n, 1 + SETTLE);
      drain();

      send(3'b011, 8'h0F, 8'hF0, 4'd5);
      send(3'b101, 8'hFF, 8'h12, 4'd6);
      drain();

      // Fill: one command parks in RESP, DEPTH more fill the FIFO.
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         f_op[i] = 3'($urandom_range(0, 7));
         f_a[i]  = W'($urandom);
         f_b[i]  = W'($urandom);
         send(f_op[i], f_a[i], f_b[i], 4'(i));
      end
      check("full_cmd_ready", {31'd0, cmd_ready}, 0);
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'h11; cmd_b = 8'h22; cmd_tag = 4'hF;
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_rsp_valid", {31'd0, rsp_valid}, 1);
         check("hold_rsp_tag", {28'd0, rsp_tag}, 0);
         check("hold_rsp_result", {24'd0, rsp_result}, {24'd0, ref_res(f_op[0], f_a[0], f_b[0])});
         check("hold_alu", {13'd0, alu_sel, alu_a, alu_b}, {13'd0, f_op[0], f_a[0], f_b[0]});
         check("hold_no_pop", {31'd0, cmd_ready}, 0);
      end
      cmd_valid = 1'b0;
      drain();

      // Throughput: continuous supply with rsp_ready=1.
      hs_cyc.delete();
      tput_on = 1'b1;
      rsp_ready = 1'b1;
      acc_cnt = 0;
      n = 0;
      while (acc_cnt < 12 && n < 200) begin
         cmd_valid = 1'b1;
         cmd_op = 3'($urandom_range(0, 7)); cmd_a = W'($urandom); cmd_b = W'($urandom);
         cmd_tag = 4'(acc_cnt);
         if (cmd_ready) acc_cnt++;
         step();
         n++;
      end
      cmd_valid = 1'b0;
      drain();
      tput_on = 1'b0;
      check("tput_count", hs_cyc.size(), 12);
      for (int i = 1; i < hs_cyc.size(); i++) begin
         check("tput_gap", hs_cyc[i] - hs_cyc[i-1], SETTLE + 1);
      end

      // Randomised traffic with random backpressure.
      for (int i = 0; i < 800; i++) begin
         cmd_valid = ($urandom_range(0, 9) < 7);
         cmd_op    = 3'($urandom_range(0, 7));
         cmd_a     = W'($urandom);
         cmd_b     = W'($urandom);
         cmd_tag   = 4'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 6);
         step();
      end
      cmd_valid = 1'b0;
      drain();

      // Reset while ISSUE with two commands queued.
      rsp_ready = 1'b0;
      send(3'd0, 8'h01, 8'h02, 4'd1);
      send(3'd1, 8'h09, 8'h03, 4'd2);
      send(3'd2, 8'h05, 8'h07, 4'd3);
      step();
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_op = 3'd6; cmd_a = 8'hAA; cmd_b = 8'h0F; cmd_tag = 4'd4;
      step();
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
      check("midrst_busy", {31'd0, busy}, 0);
      check("midrst_cmd_ready", {31'd0, cmd_ready}, 1);
      rsp_ready = 1'b1;
      n = n_rsp;
      repeat (10) step();
      check("midrst_no_stale", n_rsp - n, 0);
      check("chk_err_clean", {31'd0, chk_err}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
